alu_mdu: RTL

Parametrised successor to the single-cycle RV32 ALU, adding iterative RISC-V M-extension multiply/divide behind a valid/ready handshake. It sits in the execute stage. Base ALU ops complete in one cycle. MUL*/DIV*/REM* ops run a shift-add or restoring loop over XLEN cycles. The result is held until the consumer accepts it, so the pipeline can stall on `in_ready`/`out_valid`.

---
 rtl/alu_mdu.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_mdu.sv
// alu_mdu: single-cycle RV32-style ALU plus iterative M-extension multiply/divide behind valid/ready.
// Define ALU_MDU_DIV_EN to build the divider; without it DIV/DIVU/REM/REMU are reported as illegal.
module alu_mdu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);
  localparam int SW = $clog2(XLEN);
  localparam int CW = SW + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t            state_r, state_s;
  logic [CW-1:0]     cnt_r, cnt_s;
  logic [2*XLEN-1:0] acc_r, acc_s;
  logic [XLEN-1:0]   opnd_r, opnd_s;
  logic [2:0]        op_r, op_s;
  logic              neg_r, neg_s;
  logic [XLEN-1:0]   result_s;
  logic              illegal_s;

  logic [XLEN-1:0]   base_s;
  logic              base_ok_s;
  logic              a_sgn_s, b_sgn_s;
  logic [XLEN-1:0]   a_mag_s, b_mag_s;
  logic [2*XLEN-1:0] init_s, step_in_s, step_s, mul_step_s, prod_s;
  logic [XLEN-1:0]   init_opnd_s, step_opnd_s, fix_s;
  logic [XLEN:0]     mul_sum_s;
`ifdef ALU_MDU_DIV_EN
  logic              step_div_s, div_zero_s, div_ovf_s;
  logic [XLEN:0]     div_tmp_s, div_diff_s;
  logic [2*XLEN-1:0] div_step_s;
`endif

  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == DONE);
  assign zero      = (result == {XLEN{1'b0}});

  // Single-cycle base ALU; codes outside the table are flagged as unsupported
  always_comb begin
    base_s    = {XLEN{1'b0}};
    base_ok_s = 1'b1;
    case (op[3:0])
      4'd0:    base_s = a + b;
      4'd1:    base_s = a - b;
      4'd2:    base_s = a & b;
      4'd3:    base_s = a | b;
      4'd4:    base_s = a ^ b;
      4'd5:    base_s = a << b[SW-1:0];
      4'd6:    base_s = a >> b[SW-1:0];
      4'd7:    base_s = $signed(a) >>> b[SW-1:0];
      4'd8:    base_s = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      4'd9:    base_s = {{(XLEN-1){1'b0}}, (a < b)};
      4'd10:   base_s = b;
      default: base_ok_s = 1'b0;
    endcase
  end

  // Operand magnitudes and the shared iteration step; the first step runs in the accept cycle
  always_comb begin
    a_sgn_s     = a[XLEN-1] & (op[2] ? ~op[0] : (op[1:0] != 2'b11));
    b_sgn_s     = b[XLEN-1] & (op[2] ? ~op[0] : ~op[1]);
    a_mag_s     = a_sgn_s ? -a : a;
    b_mag_s     = b_sgn_s ? -b : b;
    init_s      = op[2] ? {{XLEN{1'b0}}, a_mag_s} : {{XLEN{1'b0}}, b_mag_s};
    init_opnd_s = op[2] ? b_mag_s : a_mag_s;
    step_in_s   = (state_r == IDLE) ? init_s : acc_r;
    step_opnd_s = (state_r == IDLE) ? init_opnd_s : opnd_r;
    mul_sum_s   = {1'b0, step_in_s[2*XLEN-1:XLEN]} + {1'b0, step_opnd_s};
    if (step_in_s[0]) begin
      mul_step_s = {mul_sum_s, step_in_s[XLEN-1:1]};
    end else begin
      mul_step_s = {1'b0, step_in_s[2*XLEN-1:1]};
    end
`ifdef ALU_MDU_DIV_EN
    step_div_s = (state_r == IDLE) ? op[2] : op_r[2];
    div_zero_s = (b == {XLEN{1'b0}});
    div_ovf_s  = ~op[0] && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == {XLEN{1'b1}});
    // restoring step: remainder:dividend shifts left, keep the difference if it did not borrow
    div_tmp_s  = step_in_s[2*XLEN-1:XLEN-1];
    div_diff_s = div_tmp_s - {1'b0, step_opnd_s};
    if (!div_diff_s[XLEN]) begin
      div_step_s = {div_diff_s[XLEN-1:0], step_in_s[XLEN-2:0], 1'b1};
    end else begin
      div_step_s = {div_tmp_s[XLEN-1:0], step_in_s[XLEN-2:0], 1'b0};
    end
    step_s = step_div_s ? div_step_s : mul_step_s;
`else
    step_s = mul_step_s;
`endif
  end

  // Fixup: restore signs, then pick product half, quotient or remainder
  always_comb begin
    prod_s = neg_r ? -acc_r : acc_r;
    fix_s  = {XLEN{1'b0}};
    case (op_r)
      3'b000:                 fix_s = prod_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_s = prod_s[2*XLEN-1:XLEN];
`ifdef ALU_MDU_DIV_EN
      3'b100, 3'b101:         fix_s = neg_r ? -acc_r[XLEN-1:0] : acc_r[XLEN-1:0];
      3'b110, 3'b111:         fix_s = neg_r ? -acc_r[2*XLEN-1:XLEN] : acc_r[2*XLEN-1:XLEN];
`endif
      default:                fix_s = {XLEN{1'b0}};
    endcase
  end

  // Next-state and datapath update
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    acc_s     = acc_r;
    opnd_s    = opnd_r;
    op_s      = op_r;
    neg_s     = neg_r;
    result_s  = result;
    illegal_s = illegal;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          op_s   = op[2:0];
          neg_s  = (op[2] & op[1]) ? a_sgn_s : (a_sgn_s ^ b_sgn_s);
          acc_s  = step_s;
          opnd_s = init_opnd_s;
          cnt_s  = CNT_ONE;
          if (!op[4]) begin
            result_s  = base_s;
            illegal_s = ~base_ok_s;
            state_s   = DONE;
          end else if (op[3]) begin
            result_s  = {XLEN{1'b0}};
            illegal_s = 1'b1;
            state_s   = DONE;
`ifdef ALU_MDU_DIV_EN
          end else if (op[2] && div_zero_s) begin
            result_s  = op[1] ? a : {XLEN{1'b1}};
            illegal_s = 1'b0;
            state_s   = DONE;
          end else if (op[2] && div_ovf_s) begin
            result_s  = op[1] ? {XLEN{1'b0}} : a;
            illegal_s = 1'b0;
            state_s   = DONE;
`else
          end else if (op[2]) begin
            result_s  = {XLEN{1'b0}};
            illegal_s = 1'b1;
            state_s   = DONE;
`endif
          end else begin
            state_s = BUSY;
          end
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        if (cnt_r == CNT_LAST) begin
          result_s  = fix_s;
          illegal_s = 1'b0;
          cnt_s     = {CW{1'b0}};
          state_s   = DONE;
        end else begin
          acc_s = step_s;
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= {CW{1'b0}};
      acc_r   <= {(2*XLEN){1'b0}};
      opnd_r  <= {XLEN{1'b0}};
      op_r    <= 3'b000;
      neg_r   <= 1'b0;
      result  <= {XLEN{1'b0}};
      illegal <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      acc_r   <= acc_s;
      opnd_r  <= opnd_s;
      op_r    <= op_s;
      neg_r   <= neg_s;
      result  <= result_s;
      illegal <= illegal_s;
    end
  end
endmodule
